uart_tx_queue: RTL and testbench

- Byte FIFO plus launch controller sitting directly upstream of the uart TX path.
- Host pushes bytes at any rate; block drains them one frame at a time by pulsing tx_en with tx_data and waiting for tx_done before launching the next byte.
- Decouples the bus-side writer from the serial bit rate set by DIV.

---
 rtl/uart_tx_queue.sv | 107 ++++++++++
 tb/tb_uart_tx_queue.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_queue.sv
// uart_tx_queue: byte FIFO feeding a uart TX, one frame in flight at a time.
// Optional tx_done watchdog enabled by defining UART_TXQ_TIMEOUT_EN.
module uart_tx_queue #(
  parameter int DEPTH       = 16,
  parameter int AW          = $clog2(DEPTH),
  parameter int TIMEOUT_CYC = 65535
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wr_en,
  input  logic [7:0]  wr_data,
  output logic        full,
  output logic        empty,
  output logic [AW:0] count,
  output logic        ovf,
  output logic        tx_en,
  output logic [7:0]  tx_data,
  input  logic        tx_done,
  output logic        busy,
  output logic        timeout
);

  typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT_CYC < 1 || TIMEOUT_CYC > 65535)
    begin : g_bad_cfg
      $error("uart_tx_queue: DEPTH must be a power of 2 >= 2, TIMEOUT_CYC in 1..65535");
    end

  state_t        state, state_nx;
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          wr_ok, pop;

  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);
  assign busy  = (state != IDLE);
  assign wr_ok = wr_en && !full;
  assign pop   = (state == IDLE) && !empty;

`ifdef UART_TXQ_TIMEOUT_EN
  localparam logic [15:0] WD_LIMIT = 16'(TIMEOUT_CYC);
  logic [15:0] wd_cnt;

  assign timeout = (state == WAIT) && (wd_cnt == WD_LIMIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_cnt <= '0;
    end else if (pop) begin
      wd_cnt <= '0;
    end else if (state == WAIT) begin
      wd_cnt <= wd_cnt + 16'd1;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  // tx_en is high only in the first WAIT cycle; a tx_done there belongs to an older frame
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (!empty) state_nx = WAIT;
      WAIT: if ((tx_done && !tx_en) || timeout) state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      ovf     <= 1'b0;
      tx_en   <= 1'b0;
      tx_data <= 8'h00;
    end else begin
      ovf   <= wr_en && full;
      tx_en <= pop;
      if (wr_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop) begin
        rd_ptr  <= rd_ptr + AW'(1);
        tx_data <= mem[rd_ptr];
      end
      case ({wr_ok, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_queue.sv
// Scoreboard bench for uart_tx_queue: stimulus queues expected bytes, a monitor
// checks every tx_en launch; directed checks cover flags, latency, reset, watchdog.
module tb_uart_tx_queue;

  localparam int DEPTH  = 16;
  localparam int AW     = 4;
  localparam int TO_CYC = 100;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          wr_en = 1'b0;
  logic [7:0]    wr_data = 8'h00;
  logic          full, empty, ovf, tx_en, busy, timeout;
  logic [AW:0]   count;
  logic [7:0]    tx_data;
  logic          tx_done;
  logic          done_main = 1'b0;
  logic          done_model = 1'b0;

  int            n_checks = 0;
  int            n_fail = 0;
  int            cyc = 0;
  int            done_cyc = -1;
  int            gap_base = 0;
  bit            auto_done = 1'b0;
  bit            chk_gap = 1'b0;
  logic [7:0]    expq[$];
  logic [7:0]    mon_exp;

  assign tx_done = done_main | done_model;

  uart_tx_queue #(.DEPTH(DEPTH), .TIMEOUT_CYC(TO_CYC)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_en),
    .wr_data (wr_data),
    .full    (full),
    .empty   (empty),
    .count   (count),
    .ovf     (ovf),
    .tx_en   (tx_en),
    .tx_data (tx_data),
    .tx_done (tx_done),
    .busy    (busy),
    .timeout (timeout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every launch must match the oldest outstanding expected byte
  always @(negedge clk) begin
    if (rst_n && tx_en) begin
      if (expq.size() == 0) begin
        check("unexpected_tx_en", tx_en, 0);
      end else begin
        mon_exp = expq.pop_front();
        check("tx_data_order", tx_data, mon_exp);
      end
      if (chk_gap && done_cyc > gap_base) check("launch_gap", cyc - done_cyc, 2);
    end
  end

  // uart model: answers tx_done 20 cycles after each observed launch
  initial forever begin
    @(negedge clk);
    if (tx_en && auto_done) begin
      repeat (20) @(posedge clk);
      #1 done_model = 1'b1;
      done_cyc = cyc;
      @(posedge clk);
      #1 done_model = 1'b0;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1, "time limit");
  end

  task automatic drive_step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_byte(input logic [7:0] d, input bit expect_out);
    drive_step();
    wr_en = 1'b1;
    wr_data = d;
    if (expect_out) expq.push_back(d);
  endtask

  task automatic idle_write();
    drive_step();
    wr_en = 1'b0;
  endtask

  task automatic pulse_done();
    drive_step();
    done_main = 1'b1;
    drive_step();
    done_main = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_full"},    full,    0);
    check({tag, "_empty"},   empty,   1);
    check({tag, "_count"},   count,   0);
    check({tag, "_ovf"},     ovf,     0);
    check({tag, "_tx_en"},   tx_en,   0);
    check({tag, "_tx_data"}, tx_data, 8'h00);
    check({tag, "_busy"},    busy,    0);
    check({tag, "_timeout"}, timeout, 0);
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (!(expq.size() == 0 && !busy && empty) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check({name, "_drained"}, (expq.size() == 0 && !busy && empty), 1);
    check({name, "_end_count"}, count, 0);
  endtask

  initial begin
    int t_en, t_to, to_hits;

    // Reset state
    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    drive_step();
    rst_n = 1'b1;

    // Single byte: count at N+1, launch at N+2 only
    write_byte(8'hA5, 1'b1);
    idle_write();
    @(negedge clk);
    check("single_count_n1", count, 1);
    check("single_no_early_tx_en", tx_en, 0);
    @(negedge clk);
    check("single_tx_en_n2", tx_en, 1);
    check("single_tx_data", tx_data, 8'hA5);
    @(negedge clk);
    check("single_tx_en_one_cycle", tx_en, 0);
    check("single_busy", busy, 1);
    check("single_count_after", count, 0);
    check("single_tx_data_held", tx_data, 8'hA5);
    repeat (5) @(negedge clk);
    check("single_still_busy", busy, 1);
    pulse_done();
    @(negedge clk);
    check("single_busy_cleared", busy, 0);

    // Back-to-back burst drained by the uart model
    gap_base = cyc;
    chk_gap = 1'b1;
    auto_done = 1'b1;
    for (int i = 0; i < 16; i++) write_byte(8'(i), 1'b1);
    idle_write();
    wait_drain("burst");
    chk_gap = 1'b0;

    // Fill while a frame is held, then overflow with 8'hEE
    auto_done = 1'b0;
    for (int i = 0; i < 17; i++) write_byte(8'(8'h30 + i), 1'b1);
    idle_write();
    @(negedge clk);
    check("fill_count", count, 16);
    check("fill_full", full, 1);
    write_byte(8'hEE, 1'b0);
    idle_write();
    @(negedge clk);
    check("ovf_pulse", ovf, 1);
    check("ovf_count_kept", count, 16);
    @(negedge clk);
    check("ovf_one_cycle", ovf, 0);
    check("ovf_still_full", full, 1);
    auto_done = 1'b1;
    pulse_done();
    wait_drain("full");

    // Push and pop in the same cycle at count=3, pointers wrap across 15->0
    auto_done = 1'b0;
    for (int i = 0; i < 4; i++) write_byte(8'(8'hB0 + i), 1'b1);
    idle_write();
    @(negedge clk);
    check("wrap_pre_count", count, 3);
    check("wrap_pre_busy", busy, 1);
    for (int i = 0; i < 40; i++) begin
      drive_step();
      done_main = 1'b1;
      drive_step();
      done_main = 1'b0;
      wr_en = 1'b1;
      wr_data = 8'(8'h40 + i);
      expq.push_back(8'(8'h40 + i));
      drive_step();
      wr_en = 1'b0;
      @(negedge clk);
      check("pushpop_count", count, 3);
      check("pushpop_launch", tx_en, 1);
    end
    auto_done = 1'b1;
    pulse_done();
    wait_drain("wrap");

    // Reset mid-WAIT with 5 bytes queued
    auto_done = 1'b0;
    write_byte(8'hE0, 1'b1);
    for (int i = 1; i < 6; i++) write_byte(8'(8'hE0 + i), 1'b0);
    idle_write();
    @(negedge clk);
    check("midrst_count", count, 5);
    check("midrst_busy", busy, 1);
    drive_step();
    rst_n = 1'b0;
    #1;
    check_reset_vals("midrst");
    drive_step();
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("postrst_no_tx_en", tx_en, 0);
    end
    check("postrst_busy", busy, 0);
    check("postrst_count", count, 0);
    write_byte(8'hC3, 1'b1);
    idle_write();
    auto_done = 1'b1;
    wait_drain("post_reset");

    // tx_done never arrives
    auto_done = 1'b0;
    write_byte(8'hD0, 1'b1);
    write_byte(8'hD1, 1'b1);
    idle_write();
    t_en = -1;
    for (int k = 0; k < 10 && t_en < 0; k++) begin
      @(negedge clk);
      if (tx_en) t_en = cyc;
    end
    check("stall_launch_seen", (t_en >= 0), 1);
`ifdef UART_TXQ_TIMEOUT_EN
    t_to = -1;
    for (int k = 0; k < 300 && t_to < 0; k++) begin
      @(negedge clk);
      if (timeout) t_to = cyc;
    end
    check("timeout_delay", t_to - t_en, TO_CYC);
    @(negedge clk);
    check("timeout_one_cycle", timeout, 0);
    check("timeout_no_early_launch", tx_en, 0);
    @(negedge clk);
    check("timeout_relaunch", tx_en, 1);
    check("timeout_relaunch_data", tx_data, 8'hD1);
    check("timeout_relaunch_gap", cyc - t_to, 2);
    wait_drain("timeout");
`else
    to_hits = 0;
    t_to = 0;
    repeat (300) begin
      @(negedge clk);
      if (timeout) to_hits++;
    end
    check("no_timeout_pulses", to_hits, t_to);
    check("no_timeout_busy", busy, 1);
    check("no_timeout_count", count, 1);
    auto_done = 1'b1;
    pulse_done();
    wait_drain("no_timeout");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
